// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MUL/DIV
// occupancy of EX, EX-resolved redirects and data-memory wait freezes.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic                  ex_is_muldiv,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_stall,
  output logic                  mem_wb_flush,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  localparam int             MDW     = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [MDW-1:0] MD_LOAD = (MULDIV_LAT > 2) ? MDW'(MULDIV_LAT - 2) : '0;
  localparam logic           MD_EN   = (MULDIV_LAT > 1);

  logic [0:0]     state;
  logic [MDW-1:0] md_cnt;
  logic           md_done;

  logic mem_wait, load_use, md_start, md_hold, md_rel;
  logic r_freeze, r_md, r_redir, r_start, r_lu;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_is_load & ex_reg_write & (ex_rd != '0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign md_start = ex_is_muldiv & ~md_done & MD_EN;
  assign md_hold  = (state == MD_WAIT) & (md_cnt != '0);
  assign md_rel   = (state == MD_WAIT) & (md_cnt == '0);

  // One-hot row select in priority order; the release cycle falls through to redirect/load-use.
  assign r_freeze = mem_wait;
  assign r_md     = ~mem_wait & md_hold;
  assign r_redir  = ~mem_wait & ~md_hold & ex_redirect;
  assign r_start  = ~mem_wait & ~md_hold & ~ex_redirect & (state == RUN) & md_start;
  assign r_lu     = ~mem_wait & ~md_hold & ~ex_redirect & ~r_start & load_use;

  assign pc_stall     = reset & (r_freeze | r_md | r_start | r_lu);
  assign if_id_stall  = reset & (r_freeze | r_md | r_start | r_lu);
  assign if_id_flush  = reset & r_redir;
  assign id_ex_stall  = reset & (r_freeze | r_md | r_start);
  assign id_ex_flush  = reset & (r_redir | r_lu);
  assign ex_mem_stall = reset & r_freeze;
  assign ex_mem_flush = reset & (r_md | r_start);
  assign mem_wb_stall = 1'b0;
  assign mem_wb_flush = reset & r_freeze;
  assign md_busy      = (state == MD_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else if (!mem_wait) begin
      if (md_hold) begin
        md_cnt <= md_cnt - MDW'(1);
      end else if (md_rel) begin
        state   <= RUN;
        md_done <= 1'b1;
      end else begin
        md_done <= 1'b0;
        if (r_start) begin
          state  <= MD_WAIT;
          md_cnt <= MD_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (r_redir && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
